lsu_xbar: RTL and testbench

//  1-master -> 2-slave AXI-lite address decoder/router; the split counterpart of the fetch/LSU arbiter.

---
 rtl/lsu_xbar.sv | 229 ++++++++++++++++++++++
 tb/tb_lsu_xbar.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_xbar.sv
// Single-master to two-slave AXI-lite router: SRAM on slave0, MMIO on slave1.
// Unmapped addresses get DECERR locally; only one transaction is in flight at a time.
module lsu_xbar #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_SIZE = 32'h0800_0000,
    parameter logic [31:0] S1_BASE = 32'ha000_0000,
    parameter logic [31:0] S1_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s0_awaddr,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    output logic [31:0] s1_awaddr,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, RD_ERR, WR_ADDR, WR_RESP, WR_ERR} state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic [1:0]  s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
    logic [1:0]  sel_oh, rd_tgt, wr_tgt;
    logic        wr_go, rd_phase, wr_phase;
    logic        sel_arready, sel_awready, sel_wready, sel_rvalid, sel_bvalid;
    logic [31:0] sel_rdata;
    logic [1:0]  sel_rresp, sel_bresp;

    // 0 = slave0, 1 = slave1, 2 = unmapped; offsets wrap so a region may straddle 2^32
    function automatic logic [1:0] decode(input logic [31:0] a);
        logic [31:0] off0, off1;
        off0 = a - S0_BASE;
        off1 = a - S1_BASE;
        if (off1 < S1_SIZE)      return 2'd1;
        else if (off0 < S0_SIZE) return 2'd0;
        else                     return 2'd2;
    endfunction

    assign rd_tgt = decode(m_araddr);
    assign wr_tgt = decode(m_awaddr);
    assign sel_oh = sel_q ? 2'b10 : 2'b01;

    assign sel_arready = sel_q ? s1_arready : s0_arready;
    assign sel_awready = sel_q ? s1_awready : s0_awready;
    assign sel_wready  = sel_q ? s1_wready  : s0_wready;
    assign sel_rvalid  = sel_q ? s1_rvalid  : s0_rvalid;
    assign sel_rdata   = sel_q ? s1_rdata   : s0_rdata;
    assign sel_rresp   = sel_q ? s1_rresp   : s0_rresp;
    assign sel_bvalid  = sel_q ? s1_bvalid  : s0_bvalid;
    assign sel_bresp   = sel_q ? s1_bresp   : s0_bresp;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m_arready = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_bvalid  = 1'b0;
        m_bresp   = '0;
        s_arvalid = '0;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_rready  = '0;
        s_bready  = '0;
        wr_go     = !m_arvalid && m_awvalid && m_wvalid;
        case (state_q)
            IDLE: begin
                m_arready = 1'b1;
                m_awready = wr_go;
                m_wready  = wr_go;
                if (m_arvalid) begin
                    addr_d  = m_araddr;
                    sel_d   = (rd_tgt == 2'd1);
                    state_d = (rd_tgt == 2'd2) ? RD_ERR : RD_ADDR;
                end else if (wr_go) begin
                    addr_d  = m_awaddr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    sel_d   = (wr_tgt == 2'd1);
                    state_d = (wr_tgt == 2'd2) ? WR_ERR : WR_ADDR;
                end
            end
            RD_ADDR: begin
                s_arvalid = sel_oh;
                if (sel_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                m_rvalid = sel_rvalid;
                m_rdata  = sel_rdata;
                m_rresp  = sel_rresp;
                s_rready = m_rready ? sel_oh : 2'b00;
                if (sel_rvalid && m_rready) state_d = IDLE;
            end
            RD_ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b11;
                if (m_rready) state_d = IDLE;
            end
            WR_ADDR: begin
                // AW and W complete independently; each valid drops once its own handshake is seen
                s_awvalid = aw_done_q ? 2'b00 : sel_oh;
                s_wvalid  = w_done_q  ? 2'b00 : sel_oh;
                aw_done_d = aw_done_q | sel_awready;
                w_done_d  = w_done_q  | sel_wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                m_bvalid = sel_bvalid;
                m_bresp  = sel_bresp;
                s_bready = m_bready ? sel_oh : 2'b00;
                if (sel_bvalid && m_bready) state_d = IDLE;
            end
            WR_ERR: begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b11;
                if (m_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign rd_phase = (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign wr_phase = (state_q == WR_ADDR) || (state_q == WR_RESP);

    assign s0_arvalid = s_arvalid[0];
    assign s1_arvalid = s_arvalid[1];
    assign s0_awvalid = s_awvalid[0];
    assign s1_awvalid = s_awvalid[1];
    assign s0_wvalid  = s_wvalid[0];
    assign s1_wvalid  = s_wvalid[1];
    assign s0_rready  = s_rready[0];
    assign s1_rready  = s_rready[1];
    assign s0_bready  = s_bready[0];
    assign s1_bready  = s_bready[1];

    assign s0_araddr = (rd_phase && !sel_q) ? addr_q  : '0;
    assign s1_araddr = (rd_phase &&  sel_q) ? addr_q  : '0;
    assign s0_awaddr = (wr_phase && !sel_q) ? addr_q  : '0;
    assign s1_awaddr = (wr_phase &&  sel_q) ? addr_q  : '0;
    assign s0_wdata  = (wr_phase && !sel_q) ? wdata_q : '0;
    assign s1_wdata  = (wr_phase &&  sel_q) ? wdata_q : '0;
    assign s0_wstrb  = (wr_phase && !sel_q) ? wstrb_q : '0;
    assign s1_wstrb  = (wr_phase &&  sel_q) ? wstrb_q : '0;

endmodule

// File: tb/tb_lsu_xbar.sv
// Bench for lsu_xbar: reactive slave models, address-map routing model, per-cycle compare
// against the transaction in flight, plus hand-computed response/latency expectations.
module tb_lsu_xbar;
    localparam logic [31:0] S0_BASE = 32'h8000_0000;
    localparam logic [31:0] S0_SIZE = 32'h0800_0000;
    localparam logic [31:0] S1_BASE = 32'ha000_0000;
    localparam logic [31:0] S1_SIZE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic [1:0] s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0][31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [1:0][3:0]  s_wstrb;
    logic [1:0][1:0]  s_rresp, s_bresp;

    lsu_xbar #(.S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
        .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
        .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
        .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
        .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
        .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
        .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1])
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // routing model: plain 64-bit range test, slave1 takes precedence, 2 = unmapped
    function automatic int route(input logic [31:0] a);
        longint unsigned ua = {32'd0, a};
        if (ua >= {32'd0, S1_BASE} && ua < {32'd0, S1_BASE} + {32'd0, S1_SIZE}) return 1;
        if (ua >= {32'd0, S0_BASE} && ua < {32'd0, S0_BASE} + {32'd0, S0_SIZE}) return 0;
        return 2;
    endfunction

    // slave configuration
    int          ar_dly[2] = '{0, 0};
    int          aw_dly[2] = '{0, 0};
    int          w_dly[2]  = '{0, 0};
    logic [31:0] rd_val[2] = '{32'hdead_beef, 32'h1234_5678};
    logic [1:0]  rr_val[2] = '{2'b00, 2'b10};
    logic [1:0]  br_val[2] = '{2'b00, 2'b00};

    // handshake monitor (pre-edge values)
    int tot_ar[2] = '{0, 0};
    int tot_aw[2] = '{0, 0};
    int tot_w[2]  = '{0, 0};
    int aw_vcyc[2] = '{0, 0};
    int w_vcyc[2]  = '{0, 0};
    int r_owed[2]  = '{0, 0};
    int aw_owed[2] = '{0, 0};
    int w_owed[2]  = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                r_owed[k] = 0; aw_owed[k] = 0; w_owed[k] = 0;
            end else begin
                if (s_arvalid[k] && s_arready[k]) begin tot_ar[k]++; r_owed[k]++; end
                if (s_rvalid[k] && s_rready[k]) r_owed[k]--;
                if (s_awvalid[k] && s_awready[k]) begin tot_aw[k]++; aw_owed[k]++; end
                if (s_wvalid[k] && s_wready[k]) begin tot_w[k]++; w_owed[k]++; end
                if (s_bvalid[k] && s_bready[k]) begin aw_owed[k]--; w_owed[k]--; end
                if (s_awvalid[k]) aw_vcyc[k]++;
                if (s_wvalid[k]) w_vcyc[k]++;
            end
        end
    end

    // slave responders
    int ar_wait[2] = '{0, 0};
    int aw_wait[2] = '{0, 0};
    int w_wait[2]  = '{0, 0};
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            s_rdata[k] = rd_val[k];
            s_rresp[k] = rr_val[k];
            s_bresp[k] = br_val[k];
            if (!rst_n) begin
                s_arready[k] = 1'b0; s_awready[k] = 1'b0; s_wready[k] = 1'b0;
                s_rvalid[k] = 1'b0; s_bvalid[k] = 1'b0;
                ar_wait[k] = 0; aw_wait[k] = 0; w_wait[k] = 0;
            end else begin
                if (s_arvalid[k]) begin s_arready[k] = (ar_wait[k] >= ar_dly[k]); ar_wait[k]++; end
                else begin s_arready[k] = 1'b0; ar_wait[k] = 0; end
                if (s_awvalid[k]) begin s_awready[k] = (aw_wait[k] >= aw_dly[k]); aw_wait[k]++; end
                else begin s_awready[k] = 1'b0; aw_wait[k] = 0; end
                if (s_wvalid[k]) begin s_wready[k] = (w_wait[k] >= w_dly[k]); w_wait[k]++; end
                else begin s_wready[k] = 1'b0; w_wait[k] = 0; end
                s_rvalid[k] = (r_owed[k] > 0);
                s_bvalid[k] = (aw_owed[k] > 0) && (w_owed[k] > 0);
            end
        end
    end

    // transaction in flight: cur_tgt 3 = none
    int          cur_tgt = 3;
    logic        cur_rd = 1'b0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    int base_ar[2], base_aw[2], base_w[2];

    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (cur_tgt != k) begin
                    check($sformatf("unsel%0d_ctl", k),
                          {27'd0, s_arvalid[k], s_awvalid[k], s_wvalid[k], s_rready[k], s_bready[k]}, 32'd0);
                    check($sformatf("unsel%0d_bus", k), s_araddr[k] | s_awaddr[k] | s_wdata[k] | {28'd0, s_wstrb[k]}, 32'd0);
                end else if (cur_rd) begin
                    check($sformatf("rd%0d_no_wr", k), {30'd0, s_awvalid[k], s_wvalid[k]}, 32'd0);
                    if (s_arvalid[k]) check($sformatf("araddr%0d", k), s_araddr[k], cur_addr);
                end else begin
                    check($sformatf("wr%0d_no_ar", k), {31'd0, s_arvalid[k]}, 32'd0);
                    if (s_awvalid[k]) check($sformatf("awaddr%0d", k), s_awaddr[k], cur_addr);
                    if (s_wvalid[k]) begin
                        check($sformatf("wdata%0d", k), s_wdata[k], cur_wdata);
                        check($sformatf("wstrb%0d", k), {28'd0, s_wstrb[k]}, {28'd0, cur_wstrb});
                    end
                end
            end
            if (cur_tgt == 3 || !cur_rd) check("m_rvalid_quiet", {31'd0, m_rvalid}, 32'd0);
            else if (m_rvalid) begin
                check("m_rdata", m_rdata, (cur_tgt == 2) ? 32'd0 : rd_val[cur_tgt]);
                check("m_rresp", {30'd0, m_rresp}, {30'd0, (cur_tgt == 2) ? 2'b11 : rr_val[cur_tgt]});
            end
            if (cur_tgt == 3 || cur_rd) check("m_bvalid_quiet", {31'd0, m_bvalid}, 32'd0);
            else if (m_bvalid)
                check("m_bresp", {30'd0, m_bresp}, {30'd0, (cur_tgt == 2) ? 2'b11 : br_val[cur_tgt]});
        end
    end

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            base_ar[k] = tot_ar[k]; base_aw[k] = tot_aw[k]; base_w[k] = tot_w[k];
        end
    endtask

    task automatic issue_rd(input logic [31:0] a);
        int n;
        cur_addr = a; cur_rd = 1'b1; cur_tgt = route(a);
        snap();
        m_araddr = a; m_arvalid = 1'b1;
        #1;
        n = 0;
        while (!m_arready && n < 50) begin next_cyc(); n++; end
        check("ar_hs_timeout", {31'd0, n < 50}, 32'd1);
        next_cyc();
        m_arvalid = 1'b0; m_araddr = '0;
    endtask

    task automatic finish_rd(output logic [31:0] d, output logic [1:0] r, output int lat);
        m_rready = 1'b1;
        #1;
        lat = 0;
        while (!m_rvalid && lat < 50) begin next_cyc(); lat++; end
        check("r_timeout", {31'd0, lat < 50}, 32'd1);
        d = m_rdata; r = m_rresp;
        next_cyc();
        m_rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ar_hs_cnt%0d", k), tot_ar[k] - base_ar[k], (cur_tgt == k) ? 32'd1 : 32'd0);
            check($sformatf("rd_no_aw%0d", k), tot_aw[k] - base_aw[k], 32'd0);
        end
        cur_tgt = 3;
    endtask

    task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        cur_addr = a; cur_wdata = d; cur_wstrb = s; cur_rd = 1'b0; cur_tgt = route(a);
        snap();
        m_awaddr = a; m_wdata = d; m_wstrb = s; m_awvalid = 1'b1; m_wvalid = 1'b1;
        #1;
        n = 0;
        while (!(m_awready && m_wready) && n < 50) begin next_cyc(); n++; end
        check("aw_hs_timeout", {31'd0, n < 50}, 32'd1);
        next_cyc();
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    endtask

    task automatic finish_wr(output logic [1:0] r);
        int n;
        m_bready = 1'b1;
        #1;
        n = 0;
        while (!m_bvalid && n < 50) begin next_cyc(); n++; end
        check("b_timeout", {31'd0, n < 50}, 32'd1);
        r = m_bresp;
        next_cyc();
        m_bready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("aw_hs_cnt%0d", k), tot_aw[k] - base_aw[k], (cur_tgt == k) ? 32'd1 : 32'd0);
            check($sformatf("w_hs_cnt%0d", k), tot_w[k] - base_w[k], (cur_tgt == k) ? 32'd1 : 32'd0);
            check($sformatf("wr_no_ar%0d", k), tot_ar[k] - base_ar[k], 32'd0);
        end
        cur_tgt = 3;
    endtask

    logic [31:0] bnd_addr[6] = '{32'h87ff_fffc, 32'h8800_0000, 32'ha000_0fff,
                                 32'ha000_1000, 32'h7fff_ffff, 32'h8000_0000};
    logic [1:0]  bnd_resp[6] = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00};

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int lat, n, aw0, w0;
        m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b0;
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b0;
        rst_n = 1'b0;
        repeat (3) next_cyc();
        check("rst_arready", {31'd0, m_arready}, 32'd1);
        check("rst_mresp_valid", {30'd0, m_rvalid, m_bvalid}, 32'd0);
        check("rst_slave_valid", {26'd0, s_arvalid, s_awvalid, s_wvalid}, 32'd0);
        rst_n = 1'b1;
        next_cyc();

        ar_dly[0] = 2;
        issue_rd(32'h8000_0010);
        check("s0_ar_next_cycle", {31'd0, s_arvalid[0]}, 32'd1);
        finish_rd(d, r, lat);
        check("rd_s0_data", d, 32'hdead_beef);
        check("rd_s0_resp", {30'd0, r}, 32'd0);
        check("rd_s0_lat", lat, 32'd3);
        ar_dly[0] = 0;

        issue_wr(32'ha000_03f8, 32'h0000_0041, 4'b0001);
        finish_wr(r);
        check("wr_s1_bresp", {30'd0, r}, 32'd0);

        issue_rd(32'h0000_1000);
        finish_rd(d, r, lat);
        check("rd_err_data", d, 32'd0);
        check("rd_err_resp", {30'd0, r}, 32'd3);
        check("rd_err_lat", lat, 32'd0);
        issue_wr(32'h0000_1000, 32'hffff_ffff, 4'hf);
        finish_wr(r);
        check("wr_err_bresp", {30'd0, r}, 32'd3);

        m_araddr = 32'ha000_0ffc; m_arvalid = 1'b1;
        m_awaddr = 32'h8000_0100; m_wdata = 32'hcafe_f00d; m_wstrb = 4'b1100;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        #1;
        check("both_arready", {31'd0, m_arready}, 32'd1);
        check("both_aw_w_blocked", {30'd0, m_awready, m_wready}, 32'd0);
        issue_rd(32'ha000_0ffc);
        m_awaddr = 32'h8000_0100; m_wdata = 32'hcafe_f00d; m_wstrb = 4'b1100;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        finish_rd(d, r, lat);
        check("rd_s1_data", d, 32'h1234_5678);
        check("rd_s1_resp", {30'd0, r}, 32'd2);
        issue_wr(32'h8000_0100, 32'hcafe_f00d, 4'b1100);
        finish_wr(r);
        check("wr_s0_bresp", {30'd0, r}, 32'd0);

        aw_dly[0] = 1; w_dly[0] = 4;
        aw0 = aw_vcyc[0]; w0 = w_vcyc[0];
        issue_wr(32'h87ff_fffc, 32'h5a5a_a5a5, 4'b1010);
        finish_wr(r);
        check("split_aw_cycles", aw_vcyc[0] - aw0, 32'd2);
        check("split_w_cycles", w_vcyc[0] - w0, 32'd5);
        aw_dly[0] = 0; w_dly[0] = 0;

        for (int i = 0; i < 6; i++) begin
            issue_rd(bnd_addr[i]);
            finish_rd(d, r, lat);
            check($sformatf("bnd_resp_%0d", i), {30'd0, r}, {30'd0, bnd_resp[i]});
        end

        issue_rd(32'h8000_0040);
        n = 0;
        while (!m_rvalid && n < 20) begin next_cyc(); n++; end
        check("rst_pre_rvalid", {31'd0, m_rvalid}, 32'd1);
        rst_n = 1'b0;
        next_cyc();
        check("midrst_rvalid", {31'd0, m_rvalid}, 32'd0);
        check("midrst_s0_rready", {31'd0, s_rready[0]}, 32'd0);
        check("midrst_arready", {31'd0, m_arready}, 32'd1);
        rst_n = 1'b1;
        cur_tgt = 3;
        next_cyc();
        issue_rd(32'h8000_0044);
        finish_rd(d, r, lat);
        check("post_rst_data", d, 32'hdead_beef);

        repeat (2) next_cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
